// File: rtl/click_decoder.sv
// -----------------------------------------------------------------------------
// click_decoder
//
// Sits directly behind the button cleanup stage and turns its one-cycle press
// pulses into click events:
//   * single_click - one press with no follow-up press inside WINDOW cycles
//   * double_click - a second press arriving within WINDOW cycles of the first
// It also keeps a running press counter for display and control logic further
// downstream.
//
// Ports:
//   clock        system clock, all logic on the rising edge
//   reset        asynchronous, active-low reset
//   clean_in     one-cycle press pulse from the button cleanup stage
//   count_clr    synchronous clear of press_count (wins over a press)
//   single_click one-cycle pulse for a lone press
//   double_click one-cycle pulse for a press pair inside the window
//   busy         high while waiting for a possible second press
//   press_count  presses since reset or clear, modulo 2^COUNT_W
// -----------------------------------------------------------------------------
module click_decoder #(
   parameter int WINDOW  = 50000,
   parameter int TIMER_W = $clog2(WINDOW),
   parameter int COUNT_W = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clean_in,
   input  logic               count_clr,
   output logic               single_click,
   output logic               double_click,
   output logic               busy,
   output logic [COUNT_W-1:0] press_count
);

   typedef enum logic {
      IDLE,
      WAIT
   } state_t;

   // The timer holds k-1 at the edge E0+k.
   // Seeing WINDOW-1 with no press therefore means the window has just run out.
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW - 1);

   state_t             state;
   logic [TIMER_W-1:0] timer;

   // Click classification state machine.
   // A first press in IDLE opens the window.
   // In WAIT, a press always wins over the timeout. This means a press on the
   // very last edge of the window still counts as a double-click.
   // Both decisions return to IDLE. A press on the following edge therefore
   // begins a fresh sequence, and a third press is never merged into a double.
   // The click pulses default low every cycle, so each one lasts exactly one
   // cycle.
   // busy is registered alongside the state so that it always equals
   // (state == WAIT).
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         timer        <= '0;
         single_click <= 1'b0;
         double_click <= 1'b0;
         busy         <= 1'b0;
      end else begin
         single_click <= 1'b0;
         double_click <= 1'b0;
         case (state)
            IDLE: begin
               if (clean_in) begin
                  state <= WAIT;
                  timer <= '0;
                  busy  <= 1'b1;
               end
            end
            WAIT: begin
               if (clean_in) begin
                  double_click <= 1'b1;
                  state        <= IDLE;
                  timer        <= '0;
                  busy         <= 1'b0;
               end else if (timer == TIMER_LAST) begin
                  single_click <= 1'b1;
                  state        <= IDLE;
                  timer        <= '0;
                  busy         <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               timer <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Press counter.
   // Every cycle with clean_in high is one press, whatever the state machine
   // is doing. The counter wraps naturally at 2^COUNT_W.
   // count_clr wins over a press on the same edge. It never touches the click
   // logic.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         press_count <= '0;
      end else if (count_clr) begin
         press_count <= '0;
      end else if (clean_in) begin
         press_count <= press_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_click_decoder.sv
// -----------------------------------------------------------------------------
// tb_click_decoder
//
// Self-checking bench for click_decoder with WINDOW = 8 and COUNT_W = 4.
// The reference model works in absolute cycle numbers: it remembers the cycle
// of the first press and measures the distance of later edges from it.
// Press counting is modelled as integer arithmetic modulo 2^COUNT_W.
// -----------------------------------------------------------------------------
module tb_click_decoder;

   localparam int WINDOW  = 8;
   localparam int COUNT_W = 4;

   logic               clock;
   logic               reset;
   logic               clean_in;
   logic               count_clr;
   logic               single_click;
   logic               double_click;
   logic               busy;
   logic [COUNT_W-1:0] press_count;

   int checks;
   int failures;

   // Reference model state
   bit pending;
   int first_cyc;
   int cyc;
   bit exp_single;
   bit exp_double;
   bit exp_busy;
   int exp_count;
   int single_seen;
   int double_seen;

   click_decoder #(
      .WINDOW (WINDOW),
      .COUNT_W(COUNT_W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .clean_in    (clean_in),
      .count_clr   (count_clr),
      .single_click(single_click),
      .double_click(double_click),
      .busy        (busy),
      .press_count (press_count)
   );

   // Free-running 10-unit clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compare every output against the model's expectation.
   task automatic checkOutput(input string tag);
      checks++;
      assert (single_click === exp_single) else begin
         failures++;
         $error("[TB] FAIL %s single_click cyc=%0d got=%b exp=%b", tag, cyc, single_click, exp_single);
      end
      checks++;
      assert (double_click === exp_double) else begin
         failures++;
         $error("[TB] FAIL %s double_click cyc=%0d got=%b exp=%b", tag, cyc, double_click, exp_double);
      end
      checks++;
      assert (busy === exp_busy) else begin
         failures++;
         $error("[TB] FAIL %s busy cyc=%0d got=%b exp=%b", tag, cyc, busy, exp_busy);
      end
      checks++;
      assert (press_count === COUNT_W'(exp_count)) else begin
         failures++;
         $error("[TB] FAIL %s press_count cyc=%0d got=%0d exp=%0d", tag, cyc, press_count, exp_count);
      end
      if (single_click === 1'b1) single_seen++;
      if (double_click === 1'b1) double_seen++;
   endtask

   // Drive one cycle of inputs, advance the model by one edge, and check
   // the outputs 1 time unit after that edge.
   task automatic applyStimulus(input bit press, input bit clr, input string tag);
      @(negedge clock);
      clean_in  = press;
      count_clr = clr;
      @(posedge clock);
      cyc++;
      exp_single = 1'b0;
      exp_double = 1'b0;
      if (pending) begin
         if (press) begin
            exp_double = 1'b1;
            pending    = 1'b0;
         end else if (cyc - first_cyc == WINDOW) begin
            exp_single = 1'b1;
            pending    = 1'b0;
         end
      end else if (press) begin
         pending   = 1'b1;
         first_cyc = cyc;
      end
      exp_busy = pending;
      if (clr)
         exp_count = 0;
      else if (press)
         exp_count = (exp_count + 1) % (1 << COUNT_W);
      #1;
      checkOutput(tag);
   endtask

   task automatic idleCycles(input int n, input string tag);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, tag);
   endtask

   task automatic modelReset();
      pending    = 1'b0;
      exp_single = 1'b0;
      exp_double = 1'b0;
      exp_busy   = 1'b0;
      exp_count  = 0;
   endtask

   initial begin
      int singles_before;
      int doubles_before;
      checks    = 0;
      failures  = 0;
      cyc       = 0;
      first_cyc = 0;
      single_seen = 0;
      double_seen = 0;
      modelReset();
      reset     = 1'b0;
      clean_in  = 1'b0;
      count_clr = 1'b0;

      // Power-on reset
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset_state");
      @(negedge clock);
      reset = 1'b1;

      // A lone press: busy spans E0..E0+8, then a single_click pulse
      applyStimulus(1'b1, 1'b0, "single_press");
      idleCycles(WINDOW + 3, "single_wait");

      // Second press at E0+3 gives a double_click
      applyStimulus(1'b1, 1'b0, "dbl3_first");
      idleCycles(2, "dbl3_gap");
      applyStimulus(1'b1, 1'b0, "dbl3_second");
      idleCycles(WINDOW + 2, "dbl3_after");

      // Second press exactly on the timeout edge E0+8 is still a double
      applyStimulus(1'b1, 1'b0, "dbl8_first");
      idleCycles(WINDOW - 1, "dbl8_gap");
      applyStimulus(1'b1, 1'b0, "dbl8_second");
      idleCycles(3, "dbl8_after");

      // Press at E0+9 is too late: single at E0+8, then a new sequence
      applyStimulus(1'b1, 1'b0, "late_first");
      idleCycles(WINDOW, "late_gap");
      applyStimulus(1'b1, 1'b0, "late_second");
      idleCycles(WINDOW + 2, "late_after");

      // Press right after a click pulse edge starts a new sequence
      applyStimulus(1'b1, 1'b0, "b2b_first");
      idleCycles(WINDOW - 1, "b2b_gap");
      applyStimulus(1'b0, 1'b0, "b2b_timeout");
      applyStimulus(1'b1, 1'b0, "b2b_restart");
      idleCycles(WINDOW + 1, "b2b_after");

      // Three presses at E0, E0+2 and E0+4: one double, then a single
      applyStimulus(1'b1, 1'b0, "tri_p1");
      applyStimulus(1'b0, 1'b0, "tri_g1");
      applyStimulus(1'b1, 1'b0, "tri_p2");
      applyStimulus(1'b0, 1'b0, "tri_g2");
      applyStimulus(1'b1, 1'b0, "tri_p3");
      idleCycles(WINDOW + 2, "tri_after");

      // Clear the counter, then send 16 isolated presses and one more
      applyStimulus(1'b0, 1'b1, "clr_only");
      singles_before = single_seen;
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b1, 1'b0, "wrap_press");
         idleCycles(19, "wrap_gap");
      end
      checks++;
      assert (single_seen - singles_before === 17) else begin
         failures++;
         $error("[TB] FAIL wrap_single_total got=%0d exp=%0d", single_seen - singles_before, 17);
      end

      // count_clr coincident with a press: the clear wins
      applyStimulus(1'b1, 1'b1, "clr_with_press");
      idleCycles(WINDOW + 2, "clr_after");

      // Reset mid-window: outputs drop at once and the press is discarded
      applyStimulus(1'b1, 1'b0, "rst_first");
      idleCycles(4, "rst_gap");
      #2;
      reset = 1'b0;
      modelReset();
      #1;
      checkOutput("async_reset");
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      singles_before = single_seen;
      idleCycles(WINDOW + 4, "rst_after");
      checks++;
      assert (single_seen === singles_before) else begin
         failures++;
         $error("[TB] FAIL rst_discard got=%0d exp=%0d", single_seen - singles_before, 0);
      end

      // Randomized traffic against the model
      doubles_before = double_seen;
      for (int i = 0; i < 600; i++) begin
         bit p;
         bit c;
         p = ($urandom_range(0, 5) == 0);
         c = ($urandom_range(0, 39) == 0);
         applyStimulus(p, c, "random");
      end
      idleCycles(WINDOW + 2, "random_drain");

      $display("[TB] random phase doubles observed: %0d", double_seen - doubles_before);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
